// File: rtl/minmax_burst_sched.sv
// Burst min/max tracker: one signed A<B comparator is shared between the
// min and max updates, one comparison per cycle, result held until acknowledged.
module minmax_burst_sched #(
  parameter int W    = 6,
  parameter int N    = 8,
  parameter int CNTW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         res_valid,
  output logic [W-1:0] res_min,
  output logic [W-1:0] res_max,
  input  logic         res_ack,
  output logic         busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] ACCEPT  = 3'd2;
  localparam logic [2:0] CMP_MIN = 3'd3;
  localparam logic [2:0] CMP_MAX = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]      state;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_inc;
  logic [W-1:0]    s_reg;
  logic [W-1:0]    min_reg;
  logic [W-1:0]    max_reg;
  logic            valid_reg;
  logic [W-1:0]    cmp_a;
  logic [W-1:0]    cmp_b;
  logic [W+1:0]    a_ext;
  logic [W+1:0]    b_ext;
  logic            a_lt_b;
  logic            xfer;
  logic            last_sample;

  // Operand mux in front of the single shared comparator.
  always_comb begin
    cmp_a = s_reg;
    cmp_b = min_reg;
    if (state == CMP_MAX) begin
      cmp_a = max_reg;
      cmp_b = s_reg;
    end
  end

  // Strict less-than derived by inverting a sign-extended >=, so ties never update.
  assign a_ext  = {{2{cmp_a[W-1]}}, cmp_a};
  assign b_ext  = {{2{cmp_b[W-1]}}, cmp_b};
  assign a_lt_b = ~($signed(a_ext) >= $signed(b_ext));

  assign in_ready    = (state == LOAD) || (state == ACCEPT);
  assign busy        = (state != IDLE);
  assign xfer        = in_valid & in_ready;
  assign cnt_inc     = cnt + 1'b1;
  assign last_sample = (cnt_inc == CNTW'(N));

  assign res_valid = valid_reg;
  assign res_min   = min_reg;
  assign res_max   = max_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      s_reg     <= '0;
      min_reg   <= '0;
      max_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      // res_valid follows DONE by one edge and drops on the edge that sees the ack.
      valid_reg <= (state == DONE) && !res_ack;
      case (state)
        IDLE: begin
          if (start) state <= LOAD;
        end
        LOAD: begin
          if (xfer) begin
            min_reg <= in_data;
            max_reg <= in_data;
            cnt     <= CNTW'(1);
            state   <= (N == 1) ? DONE : ACCEPT;
          end
        end
        ACCEPT: begin
          if (xfer) begin
            s_reg <= in_data;
            state <= CMP_MIN;
          end
        end
        CMP_MIN: begin
          if (a_lt_b) min_reg <= s_reg;
          state <= CMP_MAX;
        end
        CMP_MAX: begin
          if (a_lt_b) max_reg <= s_reg;
          cnt   <= cnt_inc;
          state <= last_sample ? DONE : ACCEPT;
        end
        DONE: begin
          if (res_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_burst_sched.sv
// Directed bench for minmax_burst_sched: N=8 main instance plus N=2 and N=1
// instances for the short-burst boundary cases.
module tb_minmax_burst_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, in_valid, res_ack;
  logic [5:0] in_data;
  logic       in_ready, res_valid, busy;
  logic [5:0] res_min, res_max;

  logic       start2, in_valid2, res_ack2;
  logic [5:0] in_data2;
  logic       in_ready2, res_valid2, busy2;
  logic [5:0] res_min2, res_max2;

  logic       start1, in_valid1, res_ack1;
  logic [5:0] in_data1;
  logic       in_ready1, res_valid1, busy1;
  logic [5:0] res_min1, res_max1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int xfer_cyc;
  int rv_cyc;
  int first_cyc;
  logic found;

  logic [5:0] t1_samples [8];
  logic [5:0] t2_samples [8];
  logic [5:0] t4_samples [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  minmax_burst_sched #(.W(6), .N(8), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .res_valid(res_valid), .res_min(res_min), .res_max(res_max),
    .res_ack(res_ack), .busy(busy)
  );

  minmax_burst_sched #(.W(6), .N(2), .CNTW(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .res_valid(res_valid2), .res_min(res_min2), .res_max(res_max2),
    .res_ack(res_ack2), .busy(busy2)
  );

  minmax_burst_sched #(.W(6), .N(1), .CNTW(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .res_valid(res_valid1), .res_min(res_min1), .res_max(res_max1),
    .res_ack(res_ack1), .busy(busy1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startBurst();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one sample (after an optional idle gap) and wait for its transfer edge.
  task automatic applyStimulus(input logic [5:0] data, input int gap);
    int guard;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) tick();
    end
    in_valid = 1'b1;
    in_data  = data;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) checkOutput("ready_timeout", {31'b0, in_ready}, 32'd1);
    tick();
    xfer_cyc = cyc;
  endtask

  // After the last transfer, in_ready must stay low until res_valid appears.
  task automatic waitResult();
    int guard;
    found = 1'b0;
    guard = 0;
    while (!found && guard < 40) begin
      if (res_valid) found = 1'b1;
      else begin
        checkOutput("ready_low_wait", {31'b0, in_ready}, 32'd0);
        tick();
        guard++;
      end
    end
    rv_cyc = cyc;
    checkOutput("result_arrived", {31'b0, found}, 32'd1);
  endtask

  task automatic ackResult();
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    checkOutput("valid_drop_after_ack", {31'b0, res_valid}, 32'd0);
    checkOutput("idle_after_ack", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    t1_samples = '{6'h05, 6'h3D, 6'h1F, 6'h00, 6'h20, 6'h07, 6'h07, 6'h3F};
    t2_samples = '{6'h2A, 6'h2A, 6'h2A, 6'h2A, 6'h2A, 6'h2A, 6'h2A, 6'h2A};
    t4_samples = '{6'h3F, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06};
    rst = 1'b1;
    start = 0; in_valid = 0; in_data = 0; res_ack = 0;
    start2 = 0; in_valid2 = 0; in_data2 = 0; res_ack2 = 0;
    start1 = 0; in_valid1 = 0; in_data1 = 0; res_ack1 = 0;
    repeat (3) tick();
    checkOutput("rst_valid", {31'b0, res_valid}, 32'd0);
    checkOutput("rst_min", {26'b0, res_min}, 32'h00);
    checkOutput("rst_max", {26'b0, res_max}, 32'h00);
    checkOutput("rst_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    // T1: mixed-sign burst, in_valid held high, timing measured from the first transfer.
    startBurst();
    checkOutput("t1_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(t1_samples[i], 0);
      if (i == 0) first_cyc = xfer_cyc;
    end
    in_valid = 1'b0;
    checkOutput("t1_xfer_span", xfer_cyc - first_cyc, 32'd19);
    waitResult();
    checkOutput("t1_latency", rv_cyc - xfer_cyc, 32'd3);
    checkOutput("t1_total", rv_cyc - first_cyc, 32'd22);
    checkOutput("t1_min", {26'b0, res_min}, 32'h20);
    checkOutput("t1_max", {26'b0, res_max}, 32'h1F);
    ackResult();
    checkOutput("t1_min_held_idle", {26'b0, res_min}, 32'h20);

    // T2: all-equal burst.
    startBurst();
    for (int i = 0; i < 8; i++) applyStimulus(t2_samples[i], 0);
    in_valid = 1'b0;
    waitResult();
    checkOutput("t2_min", {26'b0, res_min}, 32'h2A);
    checkOutput("t2_max", {26'b0, res_max}, 32'h2A);
    ackResult();

    // T3: T1 samples with random idle gaps.
    startBurst();
    for (int i = 0; i < 8; i++) applyStimulus(t1_samples[i], int'($urandom_range(0, 4)));
    in_valid = 1'b0;
    waitResult();
    checkOutput("t3_min", {26'b0, res_min}, 32'h20);
    checkOutput("t3_max", {26'b0, res_max}, 32'h1F);
    ackResult();

    // T4: reset after the 4th transfer, then a fresh burst.
    startBurst();
    for (int i = 0; i < 4; i++) applyStimulus(t1_samples[i], 0);
    in_data = t1_samples[4];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    checkOutput("t4_valid", {31'b0, res_valid}, 32'd0);
    checkOutput("t4_min", {26'b0, res_min}, 32'h00);
    checkOutput("t4_max", {26'b0, res_max}, 32'h00);
    checkOutput("t4_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("t4_busy", {31'b0, busy}, 32'd0);
    startBurst();
    for (int i = 0; i < 8; i++) applyStimulus(t4_samples[i], 0);
    in_valid = 1'b0;
    waitResult();
    checkOutput("t4_fresh_min", {26'b0, res_min}, 32'h3F);
    checkOutput("t4_fresh_max", {26'b0, res_max}, 32'h06);

    // T5: hold the result while pulsing start, then ack together with start.
    for (int i = 0; i < 10; i++) begin
      start = (i % 2 == 0);
      tick();
      checkOutput("t5_valid_hold", {31'b0, res_valid}, 32'd1);
      checkOutput("t5_min_hold", {26'b0, res_min}, 32'h3F);
      checkOutput("t5_max_hold", {26'b0, res_max}, 32'h06);
      checkOutput("t5_ready_low", {31'b0, in_ready}, 32'd0);
    end
    start = 1'b1;
    ackResult();
    start = 1'b0;
    repeat (3) tick();
    checkOutput("t5_start_ignored", {31'b0, busy}, 32'd0);
    checkOutput("t5_min_kept", {26'b0, res_min}, 32'h3F);

    // T6: N=2 sign boundary.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    in_valid2 = 1'b1;
    in_data2  = 6'h1F;
    checkOutput("t6_ready_load", {31'b0, in_ready2}, 32'd1);
    tick();
    in_data2 = 6'h20;
    checkOutput("t6_ready_accept", {31'b0, in_ready2}, 32'd1);
    tick();
    in_valid2 = 1'b0;
    repeat (3) tick();
    checkOutput("t6_valid", {31'b0, res_valid2}, 32'd1);
    checkOutput("t6_min", {26'b0, res_min2}, 32'h20);
    checkOutput("t6_max", {26'b0, res_max2}, 32'h1F);
    res_ack2 = 1'b1;
    tick();
    res_ack2 = 1'b0;
    checkOutput("t6_valid_drop", {31'b0, res_valid2}, 32'd0);

    // T7: N=1, result on the edge after the single transfer.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    in_valid1 = 1'b1;
    in_data1  = 6'h01;
    checkOutput("t7_ready_load", {31'b0, in_ready1}, 32'd1);
    tick();
    in_valid1 = 1'b0;
    checkOutput("t7_valid_at_xfer", {31'b0, res_valid1}, 32'd0);
    checkOutput("t7_busy", {31'b0, busy1}, 32'd1);
    tick();
    checkOutput("t7_valid", {31'b0, res_valid1}, 32'd1);
    checkOutput("t7_min", {26'b0, res_min1}, 32'h01);
    checkOutput("t7_max", {26'b0, res_max1}, 32'h01);
    res_ack1 = 1'b1;
    tick();
    res_ack1 = 1'b0;
    checkOutput("t7_idle", {31'b0, busy1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
